// File: rtl/ahb_simple_master.sv
// Single-outstanding AHB-Lite master: turns one command into one SINGLE transfer
// and reports completion, read data and a saturating error count.
module ahb_simple_master #(
    parameter logic [3:0] HPROT_VAL = 4'b0011,
    parameter int         ERRCNT_W  = 8
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [31:0]         cmd_addr,
    input  logic [31:0]         cmd_wdata,
    input  logic [2:0]          cmd_size,
    output logic                rsp_valid,
    output logic [31:0]         rsp_rdata,
    output logic                rsp_err,
    output logic [ERRCNT_W-1:0] err_cnt,
    output logic [31:0]         HADDR,
    output logic [1:0]          HTRANS,
    output logic                HWRITE,
    output logic [2:0]          HSIZE,
    output logic [2:0]          HBURST,
    output logic [3:0]          HPROT,
    output logic [31:0]         HWDATA,
    output logic                HMASTLOCK,
    input  logic [31:0]         HRDATA,
    input  logic                HREADY,
    input  logic [1:0]          HRESP
);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_t;

    state_t                r_state, w_state_next;
    logic [31:0]           r_haddr, w_haddr_next;
    logic [1:0]            r_htrans, w_htrans_next;
    logic                  r_hwrite, w_hwrite_next;
    logic [2:0]            r_hsize, w_hsize_next;
    logic [31:0]           r_hwdata, w_hwdata_next;
    logic [31:0]           r_wdata, w_wdata_next;
    logic                  r_cmd_ready, w_cmd_ready_next;
    logic                  r_rsp_valid, w_rsp_valid_next;
    logic                  r_rsp_err, w_rsp_err_next;
    logic [31:0]           r_rdata, w_rdata_next;
    logic [ERRCNT_W-1:0]   r_err_cnt, w_err_cnt_next;
    logic                  r_bad, w_bad_next;
    logic                  w_legal;

    always_comb begin
        case (cmd_size)
            3'b000:  w_legal = 1'b1;
            3'b001:  w_legal = ~cmd_addr[0];
            3'b010:  w_legal = (cmd_addr[1:0] == 2'b00);
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next     = r_state;
        w_haddr_next     = r_haddr;
        w_htrans_next    = r_htrans;
        w_hwrite_next    = r_hwrite;
        w_hsize_next     = r_hsize;
        w_hwdata_next    = r_hwdata;
        w_wdata_next     = r_wdata;
        w_rdata_next     = r_rdata;
        w_bad_next       = r_bad;
        w_rsp_valid_next = 1'b0;
        w_rsp_err_next   = 1'b0;
        w_err_cnt_next   = r_err_cnt;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (w_legal) begin
                        w_state_next  = ST_ADDR;
                        w_haddr_next  = cmd_addr;
                        w_htrans_next = 2'b10;
                        w_hwrite_next = cmd_write;
                        w_hsize_next  = cmd_size;
                        w_wdata_next  = cmd_wdata;
                    end else begin
                        // Rejected command: no bus activity, error reported after RESP.
                        w_state_next = ST_RESP;
                        w_bad_next   = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (HREADY) begin
                    w_state_next  = ST_DATA;
                    w_htrans_next = 2'b00;
                    w_hwdata_next = r_wdata;
                end
            end
            ST_DATA: begin
                if (HREADY) begin
                    w_state_next     = ST_RESP;
                    w_rsp_valid_next = 1'b1;
                    w_rsp_err_next   = (HRESP == 2'b01);
                    if (!r_hwrite && HRESP == 2'b00) w_rdata_next = HRDATA;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                if (r_bad) begin
                    w_rsp_valid_next = 1'b1;
                    w_rsp_err_next   = 1'b1;
                    w_bad_next       = 1'b0;
                end
            end
        endcase
        if (w_rsp_valid_next && w_rsp_err_next && r_err_cnt != '1)
            w_err_cnt_next = r_err_cnt + ERRCNT_W'(1);
        w_cmd_ready_next = (w_state_next == ST_IDLE);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_haddr     <= '0;
            r_htrans    <= 2'b00;
            r_hwrite    <= 1'b0;
            r_hsize     <= 3'b000;
            r_hwdata    <= '0;
            r_wdata     <= '0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rdata     <= '0;
            r_err_cnt   <= '0;
            r_bad       <= 1'b0;
        end else begin
            r_haddr     <= w_haddr_next;
            r_htrans    <= w_htrans_next;
            r_hwrite    <= w_hwrite_next;
            r_hsize     <= w_hsize_next;
            r_hwdata    <= w_hwdata_next;
            r_wdata     <= w_wdata_next;
            r_cmd_ready <= w_cmd_ready_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_rsp_err   <= w_rsp_err_next;
            r_rdata     <= w_rdata_next;
            r_err_cnt   <= w_err_cnt_next;
            r_bad       <= w_bad_next;
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rdata;
    assign err_cnt   = r_err_cnt;
    assign HADDR     = r_haddr;
    assign HTRANS    = r_htrans;
    assign HWRITE    = r_hwrite;
    assign HSIZE     = r_hsize;
    assign HWDATA    = r_hwdata;
    assign HBURST    = 3'b000;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb_simple_master.sv
// Bench for ahb_simple_master: acts as the AHB slave and checks each command
// against a transaction-level model of expected timing, data and error count.
module tb_ahb_simple_master;

    localparam int ERRCNT_W = 2;
    localparam int CNT_MAX  = (1 << ERRCNT_W) - 1;

    logic                HCLK;
    logic                HRESETn;
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_write;
    logic [31:0]         cmd_addr;
    logic [31:0]         cmd_wdata;
    logic [2:0]          cmd_size;
    logic                rsp_valid;
    logic [31:0]         rsp_rdata;
    logic                rsp_err;
    logic [ERRCNT_W-1:0] err_cnt;
    logic [31:0]         HADDR;
    logic [1:0]          HTRANS;
    logic                HWRITE;
    logic [2:0]          HSIZE;
    logic [2:0]          HBURST;
    logic [3:0]          HPROT;
    logic [31:0]         HWDATA;
    logic                HMASTLOCK;
    logic [31:0]         HRDATA;
    logic                HREADY;
    logic [1:0]          HRESP;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] m_rdata;
    int          m_errcnt;

    ahb_simple_master #(.ERRCNT_W(ERRCNT_W)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .err_cnt(err_cnt),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HWDATA(HWDATA), .HMASTLOCK(HMASTLOCK),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic test_reset();
        HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_size = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 2'b00;
        repeat (3) @(negedge HCLK);
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (HADDR !== 32'h0)   begin n_fail++; $display("FAIL reset_haddr got=%h exp=0", HADDR); end
            n_cmp++; if (HTRANS !== 2'b00)  begin n_fail++; $display("FAIL reset_htrans got=%b exp=00", HTRANS); end
            n_cmp++; if (HWRITE !== 1'b0 || HSIZE !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl got=%b/%b exp=0/000", HWRITE, HSIZE); end
            n_cmp++; if (HWDATA !== 32'h0)  begin n_fail++; $display("FAIL reset_hwdata got=%h exp=0", HWDATA); end
            n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
            n_cmp++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp got=%b/%b exp=0/0", rsp_valid, rsp_err); end
            n_cmp++; if (rsp_rdata !== 32'h0 || err_cnt !== '0) begin n_fail++; $display("FAIL reset_rdata_cnt got=%h/%0d exp=0/0", rsp_rdata, err_cnt); end
            n_cmp++; if (HBURST !== 3'b000 || HPROT !== 4'b0011 || HMASTLOCK !== 1'b0)
                begin n_fail++; $display("FAIL const_outputs got=%b/%b/%b exp=000/0011/0", HBURST, HPROT, HMASTLOCK); end
            HRESETn = 1'b1;
            @(negedge HCLK);
        end
        m_rdata = 32'h0; m_errcnt = 0;
        $display("reset: checked reset values");
    endtask

    // Runs one command starting at a negedge where the master is idle; returns at the
    // negedge after the completion, with the master idle again.
    task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] size, input int aw_in, input int dw_in,
                          input bit err_in, input logic [31:0] rdata);
        bit legal, err, exp_err;
        int aw, dw, rc;
        legal = (size == 3'd0) || (size == 3'd1 && addr[0] == 1'b0) ||
                (size == 3'd2 && addr[1:0] == 2'b00);
        aw = legal ? aw_in : 0;
        dw = legal ? dw_in : 0;
        err = legal && err_in && (dw >= 1);
        exp_err = !legal || err;
        rc = legal ? 3 + aw + dw : 2;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL accept_ready got=%b exp=1", cmd_ready); end
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_size = size;
        HREADY = 1'b1; HRESP = 2'b00; HRDATA = $urandom;
        for (int c = 1; c <= rc + 1; c++) begin
            @(negedge HCLK);
            if (c < rc) begin
                cmd_valid = $urandom; cmd_write = $urandom; cmd_addr = $urandom;
                cmd_wdata = $urandom; cmd_size = $urandom;
            end else begin
                cmd_valid = 1'b0;
            end
            HREADY = 1'b1; HRESP = 2'b00; HRDATA = $urandom;
            if (legal && c <= 1 + aw) begin
                n_cmp++; if (HTRANS !== 2'b10) begin n_fail++; $display("FAIL addr_htrans c=%0d got=%b exp=10", c, HTRANS); end
                n_cmp++; if (HADDR !== addr) begin n_fail++; $display("FAIL addr_haddr c=%0d got=%h exp=%h", c, HADDR, addr); end
                n_cmp++; if (HWRITE !== wr || HSIZE !== size) begin n_fail++; $display("FAIL addr_ctrl c=%0d got=%b/%b exp=%b/%b", c, HWRITE, HSIZE, wr, size); end
                n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL busy_ready c=%0d got=%b exp=0", c, cmd_ready); end
                HREADY = (c == 1 + aw);
            end else if (legal && c <= 2 + aw + dw) begin
                n_cmp++; if (HTRANS !== 2'b00) begin n_fail++; $display("FAIL data_htrans c=%0d got=%b exp=00", c, HTRANS); end
                if (wr) begin
                    n_cmp++; if (HWDATA !== wdata) begin n_fail++; $display("FAIL data_hwdata c=%0d got=%h exp=%h", c, HWDATA, wdata); end
                end
                n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL busy_ready c=%0d got=%b exp=0", c, cmd_ready); end
                HREADY = (c == 2 + aw + dw);
                if (err && c >= 1 + aw + dw) HRESP = 2'b01;
                if (c == 2 + aw + dw) HRDATA = rdata;
            end else begin
                n_cmp++; if (HTRANS !== 2'b00) begin n_fail++; $display("FAIL idle_htrans c=%0d got=%b exp=00", c, HTRANS); end
            end
            if (c == rc) begin
                if (exp_err) m_errcnt = (m_errcnt < CNT_MAX) ? m_errcnt + 1 : CNT_MAX;
                else if (!wr) m_rdata = rdata;
                n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rsp_valid c=%0d got=%b exp=1", c, rsp_valid); end
                n_cmp++; if (rsp_err !== exp_err) begin n_fail++; $display("FAIL rsp_err got=%b exp=%b", rsp_err, exp_err); end
                n_cmp++; if (rsp_rdata !== m_rdata) begin n_fail++; $display("FAIL rsp_rdata got=%h exp=%h", rsp_rdata, m_rdata); end
            end else begin
                n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rsp_valid c=%0d got=%b exp=0", c, rsp_valid); end
            end
            if (c == rc + 1) begin
                n_cmp++; if (err_cnt !== ERRCNT_W'(m_errcnt)) begin n_fail++; $display("FAIL err_cnt got=%0d exp=%0d", err_cnt, m_errcnt); end
                n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL done_ready got=%b exp=1", cmd_ready); end
            end
        end
        $display("txn %s addr=%h size=%0d aw=%0d dw=%0d err=%0d legal=%0d rsp_cycle=N+%0d",
                 wr ? "WR" : "RD", addr, size, aw, dw, err, legal, rc);
    endtask

    task automatic test_zero_wait_write();
        do_txn(1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 0, 0, 1'b0, 32'h0);
    endtask

    task automatic test_read_waits();
        do_txn(1'b0, 32'h204, 32'h0, 3'b010, 0, 2, 1'b0, 32'h12345678);
    endtask

    task automatic test_error_resp();
        do_txn(1'b0, 32'h40, 32'h0, 3'b010, 1, 0, 1'b0, 32'hA5A5C3C3);
        do_txn(1'b0, 32'h44, 32'h0, 3'b010, 0, 1, 1'b1, 32'hFFFF0000);
        do_txn(1'b1, 32'h48, 32'h0BADF00D, 3'b001, 0, 1, 1'b1, 32'h0);
    endtask

    task automatic test_misaligned();
        do_txn(1'b1, 32'h3, 32'h11111111, 3'b001, 0, 0, 1'b0, 32'h0);
        do_txn(1'b0, 32'h102, 32'h0, 3'b010, 0, 0, 1'b0, 32'h0);
        do_txn(1'b0, 32'h100, 32'h0, 3'b011, 0, 0, 1'b0, 32'h0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            logic [31:0] a;
            logic [2:0]  s;
            a = $urandom;
            s = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            do_txn(1'($urandom), a, $urandom, s, $urandom_range(0, 2), $urandom_range(0, 3),
                   ($urandom_range(0, 3) == 0), $urandom);
        end
    endtask

    task automatic test_reset_mid_transfer();
        do_txn(1'b0, 32'h500, 32'h0, 3'b010, 0, 0, 1'b0, 32'hCAFE0001);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h300; cmd_size = 3'b010;
        @(negedge HCLK);
        cmd_valid = 1'b0; HREADY = 1'b1;
        @(negedge HCLK);
        HREADY = 1'b0;
        @(negedge HCLK);
        #1 HRESETn = 1'b0;
        #1;
        n_cmp++; if (HTRANS !== 2'b00 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_imm got=%b/%b exp=00/1", HTRANS, cmd_ready); end
        n_cmp++; if (err_cnt !== '0 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_mid_clear got=%0d/%h exp=0/0", err_cnt, rsp_rdata); end
        @(negedge HCLK);
        HRESETn = 1'b1; HREADY = 1'b1;
        m_rdata = 32'h0; m_errcnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge HCLK);
            n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rsp k=%0d got=%b exp=0", k, rsp_valid); end
            n_cmp++; if (HTRANS !== 2'b00 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_idle k=%0d got=%b/%b exp=00/1", k, HTRANS, cmd_ready); end
        end
        $display("reset_mid: reset during DATA wait, idle afterwards");
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++)
            do_txn(1'b0, 32'h600 + 32'(i * 4), 32'h0, 3'b010, 0, 1 + (i % 2), 1'b1, $urandom);
        n_cmp++; if (err_cnt !== ERRCNT_W'(CNT_MAX)) begin n_fail++; $display("FAIL err_cnt_sat got=%0d exp=%0d", err_cnt, CNT_MAX); end
        $display("saturation: five errors, err_cnt=%0d", err_cnt);
    endtask

    initial begin
        test_reset();
        test_zero_wait_write();
        test_read_waits();
        test_error_resp();
        test_misaligned();
        test_random();
        test_reset_mid_transfer();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_simple_master.md
AHB_SIMPLE_MASTER -- requirements
Module: ahb_simple_master

Interface
REQ-001 The block SHALL have parameter HPROT_VAL, default 4'b0011, driven constantly on HPROT.
REQ-002 The block SHALL have parameter ERRCNT_W, default 8, giving the width of err_cnt.
REQ-003 Clocking SHALL use one clock, and reset SHALL be asynchronous and active-low.
REQ-004 HCLK  in  1  clock; all state updates on its rising edge.
REQ-005 HRESETn  in  1  asynchronous active-low reset.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-008 cmd_write  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  32  byte address.
REQ-010 cmd_wdata  in  32  write data.
REQ-011 cmd_size  in  3  HSIZE encoding; only 000, 001 and 010 are legal.
REQ-012 rsp_valid  out  1  one-cycle completion pulse.
REQ-013 rsp_rdata  out  32  read data; holds its value until the next read completes.
REQ-014 rsp_err  out  1  completion had an error; valid only with rsp_valid.
REQ-015 err_cnt  out  ERRCNT_W  saturating count of error completions.
REQ-016 HADDR, HTRANS[1:0], HWRITE, HSIZE[2:0], HBURST[2:0], HPROT[3:0], HWDATA[31:0] and HMASTLOCK  out  are the AHB master outputs.
REQ-017 HRDATA[31:0], HREADY and HRESP[1:0]  in  are the AHB inputs; HRESP encoding is 00 OKAY, 01 ERROR.

Function
REQ-018 All outputs SHALL be registered; HBURST SHALL be constant 000 (SINGLE) and HMASTLOCK constant 0.
REQ-019 The FSM SHALL have states IDLE, ADDR, DATA and RESP.
REQ-020 In IDLE, cmd_ready SHALL be 1; in every other state it SHALL be 0.
REQ-021 IDLE on acceptance with a legal, aligned command: the block SHALL latch the command and go to ADDR, driving HTRANS=10 (NONSEQ) plus HADDR, HWRITE and HSIZE on the next cycle.
REQ-022 Alignment rule: size 001 requires addr[0]=0; size 010 requires addr[1:0]=00.
REQ-023 IDLE on acceptance with an illegal size or a misaligned address: the block SHALL go to RESP and issue no bus transfer (HTRANS stays 00), then pulse rsp_valid=1 with rsp_err=1 in the next cycle.
REQ-024 ADDR: address and control SHALL stay stable while HREADY=0.
REQ-025 ADDR on HREADY=1: the block SHALL go to DATA and drive HTRANS=00; HWDATA SHALL take the latched wdata in the first DATA cycle and hold it through all DATA cycles.
REQ-026 DATA while HREADY=0: the block SHALL hold its state, including the first cycle of a two-cycle ERROR response.
REQ-027 DATA on HREADY=1: the block SHALL go to RESP.
REQ-028 On that DATA-to-RESP transition, rsp_err SHALL be set to (HRESP==01).
REQ-029 On that transition, for reads with HRESP=OKAY, rsp_rdata SHALL capture HRDATA.
REQ-030 For errored reads, rsp_rdata SHALL be left unchanged.
REQ-031 RESP: rsp_valid SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-032 Latency: an accept at cycle N with zero wait states SHALL give rsp_valid at N+3; each HREADY=0 cycle SHALL add one cycle.
REQ-033 err_cnt SHALL increment on every rsp_valid with rsp_err=1, saturate at all-ones, and never wrap.
REQ-034 Commands presented while cmd_ready=0 SHALL be ignored, with no queuing.
REQ-035 No transfer SHALL be pipelined: HTRANS SHALL be NONSEQ only in ADDR.

Reset
REQ-036 On HRESETn=0, the FSM SHALL enter IDLE immediately, including mid-transfer, and any in-flight command SHALL be discarded without a response.
REQ-037 On HRESETn=0, outputs SHALL reset to: HADDR=0, HTRANS=00, HWRITE=0, HSIZE=000, HWDATA=0, cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, err_cnt=0.

Verification
REQ-038 Zero-wait write: write addr 0x100, data 0xDEADBEEF, size 010, HREADY=1 -> NONSEQ at N+1, HWDATA=0xDEADBEEF at N+2, rsp_valid at N+3, rsp_err=0.
REQ-039 Read with waits: read addr 0x204, size 010, HREADY low 2 DATA cycles, HRDATA=0x12345678 -> rsp_valid at N+5, rsp_rdata=0x12345678, HADDR held throughout.
REQ-040 Error response: slave returns HRESP=01 with HREADY=0 then 01 with HREADY=1 -> rsp_err=1 and err_cnt=1; for a read, rsp_rdata keeps its prior value.
REQ-041 Misaligned command: addr 0x3, size 001 -> HTRANS stays 00, rsp_valid=1 and rsp_err=1 at N+2.
REQ-042 Error-count saturation: with ERRCNT_W=2, five error completions -> err_cnt=3.
REQ-043 Reset mid-transfer: HRESETn=0 during DATA with HREADY=0 -> HTRANS=00, cmd_ready=1 and no rsp_valid after release.
